return_addr_stack: RTL and testbench

//  Circular return-address stack (RAS) that supplies pop_pc, the PCSrc=2'b10 source selected by the branch/PC-select path.

---
 rtl/return_addr_stack.sv | 74 +++++++
 tb/tb_return_addr_stack.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// Circular return-address stack feeding the PCSrc=2'b10 next-PC source.
// Calls push the return PC; returns read the top entry combinationally and pop it at the edge.
module return_addr_stack #(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                push,
    input  logic [REG_BITS-1:0] push_pc,
    input  logic                pop,
    output logic [REG_BITS-1:0] pop_pc,
    output logic [PTR_BITS:0]   count,
    output logic                empty,
    output logic                full,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam logic [PTR_BITS:0] CNT_FULL = (PTR_BITS+1)'(DEPTH);

    logic [REG_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0] tp;
    logic [PTR_BITS-1:0] tp_inc;
    logic [PTR_BITS-1:0] tp_dec;
    logic [PTR_BITS:0]   cnt;
    logic                is_empty;
    logic                is_full;

    assign tp_inc   = tp + 1'b1;
    assign tp_dec   = tp - 1'b1;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            tp            <= '0;
            cnt           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clear) begin
            tp            <= '0;
            cnt           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (push && pop && !is_empty) begin
            // Return followed by call in one instruction: replace the top in place.
            mem[tp] <= push_pc;
        end else if (push) begin
            // Also covers push+pop on an empty stack: flag the underflow, then push.
            tp          <= tp_inc;
            mem[tp_inc] <= push_pc;
            if (is_full) overflow_err <= 1'b1;
            else         cnt          <= cnt + 1'b1;
            if (pop) underflow_err <= 1'b1;
        end else if (pop) begin
            if (is_empty) begin
                underflow_err <= 1'b1;
            end else begin
                tp  <= tp_dec;
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign pop_pc = is_empty ? '0 : mem[tp];
    assign count  = cnt;
    assign empty  = is_empty;
    assign full   = is_full;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed, table-driven bench for return_addr_stack (DEPTH=8).
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear, push, pop;
    logic [31:0] push_pc;
    logic [31:0] pop_pc;
    logic [3:0]  count;
    logic        empty, full, overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;

    return_addr_stack #(.REG_BITS(32), .DEPTH(8), .PTR_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .push_pc(push_pc),
        .pop(pop), .pop_pc(pop_pc), .count(count), .empty(empty), .full(full),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, psh, pp;
        logic [31:0] pc;
        logic [31:0] e_pc;
        logic [3:0]  e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(logic c, logic ph, logic pp, logic [31:0] pc,
                                logic [31:0] epc, logic [3:0] ecnt, logic eo, logic eu);
        vec_t v;
        v.clr = c; v.psh = ph; v.pp = pp; v.pc = pc;
        v.e_pc = epc; v.e_cnt = ecnt; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(string tag, logic [31:0] epc, logic [3:0] ecnt, logic eo, logic eu);
        chk({tag, ".pop_pc"}, pop_pc, epc);
        chk({tag, ".count"}, 32'(count), 32'(ecnt));
        chk({tag, ".ovf"}, 32'(overflow_err), 32'(eo));
        chk({tag, ".unf"}, 32'(underflow_err), 32'(eu));
    endtask

    // Inputs change at negedge; outputs after the edge are sampled at the following negedge.
    task automatic step(logic c, logic ph, logic pp, logic [31:0] pc);
        clear = c; push = ph; pop = pp; push_pc = pc;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; push = 1'b0; pop = 1'b0; push_pc = '0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (empty !== (count == 4'd0) || full !== (count == 4'd8)) begin
                errors++;
                $display("FAIL flags_decode: count=%0d empty=%b full=%b", count, empty, full);
            end
        end
    end

    initial begin
        tbl[0]  = mk(0,1,0,32'h100, 32'h100, 1, 0, 0);
        tbl[1]  = mk(0,1,0,32'h200, 32'h200, 2, 0, 0);
        tbl[2]  = mk(0,1,0,32'h300, 32'h300, 3, 0, 0);
        tbl[3]  = mk(0,0,1,32'h0,   32'h200, 2, 0, 0);
        tbl[4]  = mk(0,0,1,32'h0,   32'h100, 1, 0, 0);
        tbl[5]  = mk(0,0,1,32'h0,   32'h0,   0, 0, 0);
        tbl[6]  = mk(0,0,1,32'h0,   32'h0,   0, 0, 1);
        tbl[7]  = mk(0,0,0,32'h0,   32'h0,   0, 0, 1);
        tbl[8]  = mk(1,0,0,32'h0,   32'h0,   0, 0, 0);
        tbl[9]  = mk(0,1,1,32'h500, 32'h500, 1, 0, 1);
        tbl[10] = mk(1,0,0,32'h0,   32'h0,   0, 0, 0);
        tbl[11] = mk(0,1,0,32'h100, 32'h100, 1, 0, 0);
        tbl[12] = mk(0,1,0,32'h200, 32'h200, 2, 0, 0);
        tbl[13] = mk(0,1,1,32'h500, 32'h500, 2, 0, 0);
        tbl[14] = mk(0,0,1,32'h0,   32'h100, 1, 0, 0);
        tbl[15] = mk(0,0,1,32'h0,   32'h0,   0, 0, 0);
        tbl[16] = mk(0,1,0,32'h700, 32'h700, 1, 0, 0);
        tbl[17] = mk(0,0,1,32'h0,   32'h0,   0, 0, 0);
        tbl[18] = mk(0,0,1,32'h0,   32'h0,   0, 0, 1);
        tbl[19] = mk(1,1,0,32'h800, 32'h0,   0, 0, 0);

        reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_pc = '0;
        repeat (2) @(negedge clk);
        chk_state("reset", 32'h0, 0, 0, 0);
        chk("reset.empty", 32'(empty), 32'd1);
        chk("reset.full", 32'(full), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].clr, tbl[i].psh, tbl[i].pp, tbl[i].pc);
            chk_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf);
        end

        // Old top is visible during the push+pop cycle itself.
        step(0, 1, 0, 32'h100);
        step(0, 1, 0, 32'h200);
        push = 1'b1; pop = 1'b1; push_pc = 32'h500;
        #1 chk("pushpop.old_top", pop_pc, 32'h200);
        @(posedge clk); @(negedge clk);
        push = 1'b0; pop = 1'b0;
        chk_state("pushpop.after", 32'h500, 2, 0, 0);
        step(1, 0, 0, 32'h0);

        // Overflow: nine pushes into eight entries; the oldest is lost.
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 32'(i * 16));
        chk_state("ovf.after_push", 32'h90, 8, 1, 0);
        chk("ovf.full", 32'(full), 32'd1);
        for (int i = 9; i >= 2; i--) begin
            chk($sformatf("ovf.pop%0d", i), pop_pc, 32'(i * 16));
            step(0, 0, 1, 32'h0);
        end
        chk_state("ovf.drained", 32'h0, 0, 1, 0);
        chk("ovf.empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle with a push in flight.
        step(0, 1, 0, 32'h55);
        chk_state("pre_rst", 32'h55, 1, 1, 0);
        push = 1'b1; push_pc = 32'h66;
        #2 reset_n = 1'b0;
        #1 chk_state("async_rst", 32'h0, 0, 0, 0);
        chk("async_rst.empty", 32'(empty), 32'd1);
        @(negedge clk);
        chk_state("rst_held", 32'h0, 0, 0, 0);
        reset_n = 1'b1; push_pc = 32'hAB;
        @(posedge clk); @(negedge clk);
        push = 1'b0;
        chk_state("post_rst", 32'hAB, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
